// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write sequencer: IDLE -> READ -> WRITE -> RESP, one instruction per transaction.
// Optional macro CSR_RO_TRAP_EN: writes to the read-only space (addr[11:10]==11) trap as illegal instead of being dropped.
module csr_access_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_rs1_data,
  input  logic [4:0]        req_rs1_idx,
  output logic [ADDR_W-1:0] csraddr,
  output logic              csrwe,
  output logic [WIDTH-1:0]  csrindata,
  input  logic [WIDTH-1:0]  csroutdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WIDTH-1:0]  resp_data,
  output logic              resp_illegal,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [1:0]        r_op;
  logic [WIDTH-1:0]  r_operand;
  logic              r_we;
  logic              r_illegal;
  logic [ADDR_W-1:0] r_csraddr;
  logic [WIDTH-1:0]  r_wdata;
  logic [WIDTH-1:0]  r_resp_data;
  logic              r_resp_illegal;

  logic              w_accept;
  logic [1:0]        w_op;
  logic [WIDTH-1:0]  w_operand;
  logic              w_do_write;
  logic              w_ro;
  logic              w_bad_op;
  logic              w_illegal;
  logic              w_we;
  logic [WIDTH-1:0]  w_new_val;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // req_ready is high only in IDLE, and RESP holds its outputs until resp_ready is seen.
  assign w_accept   = req_valid & (r_state == S_IDLE);
  assign w_op       = req_funct3[1:0];
  assign w_operand  = req_funct3[2] ? {{(WIDTH-5){1'b0}}, req_rs1_idx} : req_rs1_data;
  assign w_do_write = (w_op == 2'b01) | (req_rs1_idx != 5'd0);
  assign w_ro       = (req_addr[ADDR_W-1 -: 2] == 2'b11);
  assign w_bad_op   = (w_op == 2'b00);
`ifdef CSR_RO_TRAP_EN
  assign w_illegal  = w_bad_op | (w_do_write & w_ro);
`else
  assign w_illegal  = w_bad_op;
`endif
  // Read-only targets never get a strobe; the macro only decides whether that is reported.
  assign w_we       = w_do_write & ~w_bad_op & ~w_ro;

  always_comb begin
    w_new_val = csroutdata;
    case (r_op)
      2'b01:   w_new_val = r_operand;
      2'b10:   w_new_val = csroutdata | r_operand;
      2'b11:   w_new_val = csroutdata & ~r_operand;
      default: w_new_val = csroutdata;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next_state = S_READ;
      S_READ:  w_next_state = S_WRITE;
      S_WRITE: w_next_state = S_RESP;
      S_RESP:  if (resp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op           <= 2'b00;
      r_operand      <= '0;
      r_we           <= 1'b0;
      r_illegal      <= 1'b0;
      r_csraddr      <= '0;
      r_wdata        <= '0;
      r_resp_data    <= '0;
      r_resp_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= w_op;
        r_operand <= w_operand;
        r_we      <= w_we;
        r_illegal <= w_illegal;
        r_csraddr <= req_addr;
      end
      if (r_state == S_READ) begin
        r_wdata        <= w_new_val;
        r_resp_data    <= r_illegal ? '0 : csroutdata;
        r_resp_illegal <= r_illegal;
      end
    end
  end

  // csrwe is decoded from the async-reset state so it falls the instant rst asserts.
  assign csrwe        = (r_state == S_WRITE) & r_we;
  assign csraddr      = r_csraddr;
  assign csrindata    = r_wdata;
  assign req_ready    = (r_state == S_IDLE);
  assign resp_valid   = (r_state == S_RESP);
  assign resp_data    = r_resp_data;
  assign resp_illegal = r_resp_illegal;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit: a bench-side CSR file, a rule-level model with expected queues,
// a per-cycle monitor, and literal expectations per test-plan vector.
module tb_csr_access_unit;
  localparam int W  = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_rs1_data;
  logic [4:0]    req_rs1_idx;
  logic [AW-1:0] csraddr;
  logic          csrwe;
  logic [W-1:0]  csrindata;
  logic [W-1:0]  csroutdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [W-1:0]  resp_data;
  logic          resp_illegal;
  logic [1:0]    dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  // clock / reset block
  always #5 clk = ~clk;

  csr_access_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs1_data(req_rs1_data), .req_rs1_idx(req_rs1_idx),
    .csraddr(csraddr), .csrwe(csrwe), .csrindata(csrindata), .csroutdata(csroutdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_illegal(resp_illegal), .dbg_state(dbg_state)
  );

  // bench-side CSR file: combinational read, written on csrwe or by a poke
  logic [W-1:0]  csr_mem [0:4095];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [W-1:0]  poke_data = '0;

  assign csroutdata = csr_mem[csraddr];

  always @(posedge clk) begin
    if (poke_en) csr_mem[poke_addr] <= poke_data;
    else if (csrwe) csr_mem[csraddr] <= csrindata;
  end

  // scoreboard
  logic [AW+W-1:0] exp_wr_q[$];
  logic [W:0]      exp_rsp_q[$];
  logic [AW+W-1:0] e_wr;
  logic [W:0]      e_rsp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Zicsr rules: what the CSR file must see and what the core must get back
  function automatic void model(input logic [2:0] f3, input logic [AW-1:0] addr,
                                input logic [W-1:0] rs1, input logic [4:0] idx,
                                input logic [W-1:0] old, output logic has_wr,
                                output logic [W-1:0] wdata, output logic [W-1:0] rdata,
                                output logic ill);
    logic [W-1:0] opnd;
    logic         wants_write;
    opnd        = f3[2] ? W'(idx) : rs1;
    wants_write = (f3[1:0] == 2'b01) || (idx != 5'd0);
    has_wr = 1'b0; wdata = '0; rdata = old; ill = 1'b0;
    if (f3[1:0] == 2'b00) begin
      ill = 1'b1; rdata = '0;
    end else if (wants_write && addr[11:10] == 2'b11) begin
`ifdef CSR_RO_TRAP_EN
      ill = 1'b1; rdata = '0;
`endif
    end else if (wants_write) begin
      has_wr = 1'b1;
      if (f3[1:0] == 2'b01)      wdata = opnd;
      else if (f3[1:0] == 2'b10) wdata = old | opnd;
      else                       wdata = old & ~opnd;
    end
  endfunction

  // compare process: every write strobe and every response transfer is checked
  always @(negedge clk) begin
    if (rst) begin
      if (csrwe) begin
        if (exp_wr_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: csrwe 1 at addr 0x%0h data 0x%0h, expected no write", csraddr, csrindata);
        end else begin
          e_wr = exp_wr_q.pop_front();
          check("wr_addr", 64'(csraddr), 64'(e_wr[AW+W-1:W]));
          check("wr_data", 64'(csrindata), 64'(e_wr[W-1:0]));
        end
      end
      if (resp_valid && resp_ready) begin
        if (exp_rsp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_resp: resp_valid 1 data 0x%0h, expected no response", resp_data);
        end else begin
          e_rsp = exp_rsp_q.pop_front();
          check("mon_resp_data", 64'(resp_data), 64'(e_rsp[W-1:0]));
          check("mon_resp_illegal", 64'(resp_illegal), 64'(e_rsp[W]));
        end
      end
    end
  end

  // driver tasks
  task automatic poke(input logic [AW-1:0] a, input logic [W-1:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic run_csr(input logic [2:0] f3, input logic [AW-1:0] addr,
                         input logic [W-1:0] rs1, input logic [4:0] idx,
                         input int hold, input bit abort,
                         output logic got_we, output logic [W-1:0] got_wdata,
                         output logic [W-1:0] got_rdata, output logic got_ill);
    logic         has_wr, ill;
    logic [W-1:0] wd, rd, old;
    int           guard;
    old = csr_mem[addr];
    model(f3, addr, rs1, idx, old, has_wr, wd, rd, ill);
    if (has_wr) exp_wr_q.push_back({addr, wd});
    exp_rsp_q.push_back({ill, rd});
    resp_ready   = (hold == 0);
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_addr     = addr;
    req_rs1_data = rs1;
    req_rs1_idx  = idx;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) begin
      n_total++;
      $display("FAIL req_ready_timeout: req_ready 0 for 20 cycles, expected 1");
    end
    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_rs1_data = $urandom();
    req_rs1_idx  = 5'($urandom_range(0, 31));
    req_funct3   = 3'($urandom_range(0, 7));
    @(negedge clk);
    check("read_csraddr", 64'(csraddr), 64'(addr));
    check("read_no_we", 64'(csrwe), 64'd0);
    check("read_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    got_we    = csrwe;
    got_wdata = csrindata;
    check("write_strobe", 64'(csrwe), 64'(has_wr));
    check("write_no_resp", 64'(resp_valid), 64'd0);
    if (abort) begin
      #2 rst = 1'b0;
      #1 check("abort_we_async", 64'(csrwe), 64'd0);
      exp_rsp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      check("abort_state", 64'(dbg_state), 64'd0);
      check("abort_resp_valid", 64'(resp_valid), 64'd0);
      got_rdata = '0;
      got_ill   = 1'b0;
    end else begin
      @(negedge clk);
      check("resp_valid_n3", 64'(resp_valid), 64'd1);
      check("resp_data", 64'(resp_data), 64'(rd));
      check("resp_illegal", 64'(resp_illegal), 64'(ill));
      got_rdata = resp_data;
      got_ill   = resp_illegal;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", 64'(resp_valid), 64'd1);
        check("hold_data", 64'(resp_data), 64'(rd));
        check("hold_illegal", 64'(resp_illegal), 64'(ill));
        check("hold_req_ready", 64'(req_ready), 64'd0);
      end
      if (hold > 0) begin
        @(posedge clk); #1;
        resp_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("idle_req_ready", 64'(req_ready), 64'd1);
    check("wr_q_drained", 64'(exp_wr_q.size()), 64'd0);
    check("rsp_q_drained", 64'(exp_rsp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  logic         g_we, g_il;
  logic [W-1:0] g_wd, g_rd;

  initial begin
    req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_rs1_data = '0;
    req_rs1_idx = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_csraddr", 64'(csraddr), 64'd0);
    check("rst_csrwe", 64'(csrwe), 64'd0);
    check("rst_csrindata", 64'(csrindata), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_resp_illegal", 64'(resp_illegal), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    poke(12'h340, 32'h12345678);
    poke(12'hC00, 32'h00000064);
    poke(12'h300, 32'hAAAA0000);
    rst = 1'b1;
    @(posedge clk); #1;

    // CSRRW
    run_csr(3'b001, 12'h340, 32'hDEADBEEF, 5'd5, 0, 1'b0, g_we, g_wd, g_rd, g_il);
    check("t1_we", 64'(g_we), 64'd1);
    check("t1_wdata", 64'(g_wd), 64'hDEADBEEF);
    check("t1_rdata", 64'(g_rd), 64'h12345678);
    check("t1_ill", 64'(g_il), 64'd0);
    check("t1_mem", 64'(csr_mem[12'h340]), 64'hDEADBEEF);

    // CSRRS then CSRRCI
    poke(12'h340, 32'h0000000F);
    run_csr(3'b010, 12'h340, 32'h000000F0, 5'd3, 0, 1'b0, g_we, g_wd, g_rd, g_il);
    check("t2_wdata", 64'(g_wd), 64'h000000FF);
    check("t2_rdata", 64'(g_rd), 64'h0000000F);
    run_csr(3'b111, 12'h340, 32'hFFFFFFFF, 5'h0F, 0, 1'b0, g_we, g_wd, g_rd, g_il);
    check("t3_wdata", 64'(g_wd), 64'h000000F0);
    check("t3_rdata", 64'(g_rd), 64'h000000FF);

    // CSRRS x0 on read-only counter: legal read, no write
    run_csr(3'b010, 12'hC00, 32'h00012345, 5'd0, 0, 1'b0, g_we, g_wd, g_rd, g_il);
    check("t4_we", 64'(g_we), 64'd0);
    check("t4_rdata", 64'(g_rd), 64'h00000064);
    check("t4_ill", 64'(g_il), 64'd0);

    // CSRRW to read-only space
    run_csr(3'b001, 12'hC00, 32'h00000001, 5'd1, 0, 1'b0, g_we, g_wd, g_rd, g_il);
    check("t5_we", 64'(g_we), 64'd0);
`ifdef CSR_RO_TRAP_EN
    check("t5_rdata", 64'(g_rd), 64'd0);
    check("t5_ill", 64'(g_il), 64'd1);
`else
    check("t5_rdata", 64'(g_rd), 64'h00000064);
    check("t5_ill", 64'(g_il), 64'd0);
`endif
    check("t5_mem", 64'(csr_mem[12'hC00]), 64'h00000064);

    // funct3 000 with 10 cycles of back-pressure, then 100
    run_csr(3'b000, 12'h340, 32'h0000FFFF, 5'd7, 10, 1'b0, g_we, g_wd, g_rd, g_il);
    check("t6_we", 64'(g_we), 64'd0);
    check("t6_rdata", 64'(g_rd), 64'd0);
    check("t6_ill", 64'(g_il), 64'd1);
    run_csr(3'b100, 12'h340, 32'h0, 5'd9, 0, 1'b0, g_we, g_wd, g_rd, g_il);
    check("t7_we", 64'(g_we), 64'd0);
    check("t7_ill", 64'(g_il), 64'd1);
    check("t7_mem", 64'(csr_mem[12'h340]), 64'h000000F0);

    // CSRRS with nonzero index but zero data still writes
    run_csr(3'b010, 12'h340, 32'h0, 5'd4, 0, 1'b0, g_we, g_wd, g_rd, g_il);
    check("t8_we", 64'(g_we), 64'd1);
    check("t8_wdata", 64'(g_wd), 64'h000000F0);

    // CSRRWI, CSRRC, CSRRSI x0
    run_csr(3'b101, 12'h300, 32'h12345678, 5'h1F, 0, 1'b0, g_we, g_wd, g_rd, g_il);
    check("t9_wdata", 64'(g_wd), 64'h0000001F);
    check("t9_rdata", 64'(g_rd), 64'hAAAA0000);
    run_csr(3'b011, 12'h300, 32'h00000003, 5'd2, 0, 1'b0, g_we, g_wd, g_rd, g_il);
    check("t10_wdata", 64'(g_wd), 64'h0000001C);
    check("t10_rdata", 64'(g_rd), 64'h0000001F);
    run_csr(3'b110, 12'h300, 32'hFFFFFFFF, 5'd0, 0, 1'b0, g_we, g_wd, g_rd, g_il);
    check("t11_we", 64'(g_we), 64'd0);
    check("t11_rdata", 64'(g_rd), 64'h0000001C);

`ifndef CSR_RO_TRAP_EN
    // CSRRSI with nonzero zimm on read-only space is dropped silently
    run_csr(3'b110, 12'hC00, 32'h0, 5'd1, 0, 1'b0, g_we, g_wd, g_rd, g_il);
    check("t12_we", 64'(g_we), 64'd0);
    check("t12_rdata", 64'(g_rd), 64'h00000064);
    check("t12_ill", 64'(g_il), 64'd0);
`endif

    // reset during the WRITE cycle abandons the write
    run_csr(3'b001, 12'h340, 32'h00000055, 5'd6, 0, 1'b1, g_we, g_wd, g_rd, g_il);
    check("t13_we_seen", 64'(g_we), 64'd1);
    check("t13_mem_kept", 64'(csr_mem[12'h340]), 64'h000000F0);

    // recovery after reset
    run_csr(3'b001, 12'h340, 32'hCAFEF00D, 5'd8, 0, 1'b0, g_we, g_wd, g_rd, g_il);
    check("t14_wdata", 64'(g_wd), 64'hCAFEF00D);
    check("t14_rdata", 64'(g_rd), 64'h000000F0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
